// File: rtl/kgp_pc_pkg.sv
// Shared types for the KGP fetch path: PC width, FSM states and next-PC select codes.
package kgp_pc_pkg;

  // Must match the width of the external PC increment stage.
  localparam int unsigned PC_W = 13;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalt
  } state_e;

  typedef enum logic [1:0] {
    SelHold,
    SelInc,
    SelBranch,
    SelJump
  } next_sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority encoder and mux. Purely combinational.
// Only RUN moves the PC. Priority is halt_req > jump > branch > stall > increment.
// A redirect overrides a stall because the stalled younger instruction is flushed.
module pc_next_sel
  import kgp_pc_pkg::*;
(
  input  state_e state_i,
  input  logic   halt_req_i,
  input  logic   jump_i,
  input  logic   branch_taken_i,
  input  logic   stall_i,
  input  pc_t    pc_i,
  input  pc_t    pc_inc_i,
  input  pc_t    branch_target_i,
  input  pc_t    jump_target_i,
  output pc_t    next_pc_o,
  output logic   redirect_o
);

  next_sel_e sel;

  // Resolve which source feeds the PC register on the next edge.
  always_comb begin
    sel = SelHold;
    if ((state_i == StRun) && !halt_req_i) begin
      if (jump_i) begin
        sel = SelJump;
      end else if (branch_taken_i) begin
        sel = SelBranch;
      end else if (!stall_i) begin
        sel = SelInc;
      end
    end
  end

  // Next-PC mux. Targets and the incremented value are used verbatim.
  always_comb begin
    next_pc_o = pc_i;
    unique case (sel)
      SelHold:   next_pc_o = pc_i;
      SelInc:    next_pc_o = pc_inc_i;
      SelBranch: next_pc_o = branch_target_i;
      SelJump:   next_pc_o = jump_target_i;
      default:   next_pc_o = pc_i;
    endcase
  end

  assign redirect_o = (sel == SelJump) || (sel == SelBranch);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter register, BOOT/RUN/HALT sequencing and redirect flag for the
// KGP fetch path. Optional fetch counter is enabled by defining PC_FETCH_PERF_CNT_EN.
module pc_fetch_unit
  import kgp_pc_pkg::*;
#(
  parameter pc_t         RESET_PC   = '0,
  parameter int unsigned BOOT_DELAY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_inc,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            halt_req,
  input  logic            resume,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            halted,
  output logic            redirect
`ifdef PC_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_count
`endif
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  pc_t        pc_q, pc_d;
  logic       redirect_q, redirect_d;
  logic       boot_done;

  pc_next_sel u_next_sel (
    .state_i         (state_q),
    .halt_req_i      (halt_req),
    .jump_i          (jump),
    .branch_taken_i  (branch_taken),
    .stall_i         (stall),
    .pc_i            (pc_q),
    .pc_inc_i        (pc_inc),
    .branch_target_i (branch_target),
    .jump_target_i   (jump_target),
    .next_pc_o       (pc_d),
    .redirect_o      (redirect_d)
  );

  // Leave BOOT on the edge where the counter reaches BOOT_DELAY. With a delay of
  // 0 or 1 this is the first edge after reset release.
  assign boot_done = ({1'b0, cnt_q} + 5'd1) >= 5'(BOOT_DELAY);

  // FSM next state and boot counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StBoot: begin
        cnt_d = cnt_q + 4'd1;
        if (boot_done) state_d = StRun;
      end
      StRun: begin
        if (halt_req) state_d = StHalt;
      end
      StHalt: begin
        if (resume && !halt_req) state_d = StRun;
      end
      default: state_d = StBoot;
    endcase
  end

  // State, PC and redirect registers. Reset is asynchronous and restarts BOOT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StBoot;
      cnt_q      <= '0;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc          = pc_q;
  assign redirect    = redirect_q;
  assign fetch_valid = (state_q == StRun);
  assign halted      = (state_q == StHalt);

`ifdef PC_FETCH_PERF_CNT_EN
  logic [31:0] count_q;
  logic        advance;

  // PC advances in RUN unless halting or stalled without a redirect.
  assign advance = (state_q == StRun) && !halt_req && (redirect_d || !stall);

  // Saturating count of PC advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (advance && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit (RESET_PC=0, BOOT_DELAY=2).
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic [12:0] pc_inc;
  logic        stall;
  logic        branch_taken;
  logic [12:0] branch_target;
  logic        jump;
  logic [12:0] jump_target;
  logic        halt_req;
  logic        resume;
  logic [12:0] pc;
  logic        fetch_valid;
  logic        halted;
  logic        redirect;
`ifdef PC_FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_unit #(
    .RESET_PC   (13'h0000),
    .BOOT_DELAY (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_inc        (pc_inc),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt_req      (halt_req),
    .resume        (resume),
    .pc            (pc),
    .fetch_valid   (fetch_valid),
    .halted        (halted),
    .redirect      (redirect)
`ifdef PC_FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  // Increment stage stand-in: 13-bit pc + 1 with natural wrap.
  assign pc_inc = pc + 13'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall        = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    halt_req     = 1'b0;
    resume       = 1'b0;
  endtask

  // Expected pc and fetch_valid across boot: two idle cycles, then 0,1,2,3.
  logic [12:0] boot_pc [6] = '{13'h0, 13'h0, 13'h0, 13'h1, 13'h2, 13'h3};
  logic        boot_fv [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    rst           = 1'b1;
    branch_target = '0;
    jump_target   = '0;
    clear_ctl();
    tick();
    check_eq("rst_pc", 32'(pc), 32'h0);
    check_eq("rst_fetch_valid", 32'(fetch_valid), 32'h0);
    check_eq("rst_halted", 32'(halted), 32'h0);
    check_eq("rst_redirect", 32'(redirect), 32'h0);
    // Boot inputs are ignored: a jump here must not move pc.
    jump        = 1'b1;
    jump_target = 13'h0777;
    rst         = 1'b0;

    // 1. Boot sequence.
    for (int i = 0; i < 6; i++) begin
      if (i == 2) clear_ctl();
      check_eq($sformatf("boot_pc[%0d]", i), 32'(pc), 32'(boot_pc[i]));
      check_eq($sformatf("boot_fv[%0d]", i), 32'(fetch_valid), 32'(boot_fv[i]));
      tick();
    end
    // Now pc=4.
    check_eq("run_pc4", 32'(pc), 32'h4);
    tick();
    check_eq("run_pc5", 32'(pc), 32'h5);

    // 2. Jump beats branch beats stall.
    jump          = 1'b1;
    jump_target   = 13'h0100;
    branch_taken  = 1'b1;
    branch_target = 13'h0040;
    stall         = 1'b1;
    tick();
    clear_ctl();
    check_eq("prio_pc", 32'(pc), 32'h0100);
    check_eq("prio_redirect", 32'(redirect), 32'h1);
    tick();
    check_eq("prio_next_pc", 32'(pc), 32'h0101);
    check_eq("prio_redirect_drop", 32'(redirect), 32'h0);

    // 3. Stall at 0x0010 (reached with a branch).
    branch_taken  = 1'b1;
    branch_target = 13'h0010;
    tick();
    check_eq("br_pc", 32'(pc), 32'h0010);
    check_eq("br_redirect", 32'(redirect), 32'h1);
    branch_taken = 1'b0;
    stall        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("stall_pc[%0d]", i), 32'(pc), 32'h0010);
      check_eq($sformatf("stall_fv[%0d]", i), 32'(fetch_valid), 32'h1);
      check_eq($sformatf("stall_redirect[%0d]", i), 32'(redirect), 32'h0);
    end
    stall = 1'b0;
    tick();
    check_eq("stall_release_pc", 32'(pc), 32'h0011);

    // 4. Wrap through 0x1FFF.
    jump        = 1'b1;
    jump_target = 13'h1FFE;
    tick();
    clear_ctl();
    check_eq("wrap_pc0", 32'(pc), 32'h1FFE);
    check_eq("wrap_redir0", 32'(redirect), 32'h1);
    tick();
    check_eq("wrap_pc1", 32'(pc), 32'h1FFF);
    check_eq("wrap_redir1", 32'(redirect), 32'h0);
    tick();
    check_eq("wrap_pc2", 32'(pc), 32'h0000);
    check_eq("wrap_redir2", 32'(redirect), 32'h0);
    tick();
    check_eq("wrap_pc3", 32'(pc), 32'h0001);

    // 5. Halt at 0x0020.
    jump        = 1'b1;
    jump_target = 13'h0020;
    tick();
    clear_ctl();
    check_eq("halt_entry_pc", 32'(pc), 32'h0020);
    halt_req = 1'b1;
    tick();
    check_eq("halt_halted", 32'(halted), 32'h1);
    check_eq("halt_fv", 32'(fetch_valid), 32'h0);
    check_eq("halt_pc", 32'(pc), 32'h0020);
    halt_req    = 1'b0;
    jump        = 1'b1;
    jump_target = 13'h0300;
    tick();
    check_eq("halt_jump_pc", 32'(pc), 32'h0020);
    check_eq("halt_jump_redirect", 32'(redirect), 32'h0);
    check_eq("halt_jump_halted", 32'(halted), 32'h1);
    jump     = 1'b0;
    halt_req = 1'b1;
    resume   = 1'b1;
    tick();
    check_eq("halt_both_halted", 32'(halted), 32'h1);
    check_eq("halt_both_pc", 32'(pc), 32'h0020);
    halt_req = 1'b0;
    tick();
    resume = 1'b0;
    check_eq("resume_halted", 32'(halted), 32'h0);
    check_eq("resume_fv", 32'(fetch_valid), 32'h1);
    check_eq("resume_pc", 32'(pc), 32'h0020);
    tick();
    check_eq("resume_next_pc", 32'(pc), 32'h0021);

    // 6. Async reset while redirect is high.
    jump        = 1'b1;
    jump_target = 13'h0555;
    tick();
    clear_ctl();
    check_eq("pre_rst_pc", 32'(pc), 32'h0555);
    check_eq("pre_rst_redirect", 32'(redirect), 32'h1);
`ifdef PC_FETCH_PERF_CNT_EN
    // 5 boot-run incs, 2 after first jump, branch, 0x11, 4 in wrap, 0x20, 0x21, 0x555.
    check_eq("perf_count", fetch_count, 32'd16);
`endif
    rst = 1'b1;
    #1;
    check_eq("async_rst_pc", 32'(pc), 32'h0);
    check_eq("async_rst_redirect", 32'(redirect), 32'h0);
    check_eq("async_rst_fv", 32'(fetch_valid), 32'h0);
`ifdef PC_FETCH_PERF_CNT_EN
    check_eq("async_rst_count", fetch_count, 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    check_eq("reboot_fv1", 32'(fetch_valid), 32'h0);
    tick();
    check_eq("reboot_fv2", 32'(fetch_valid), 32'h1);
    check_eq("reboot_pc", 32'(pc), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog in case the clock or the run stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and next-PC selection stage for the KGP RISC fetch path.
- Drives the 13-bit instruction address to instruction memory and to the PC increment stage. Consumes the incremented value that stage returns.
- Arbitrates among sequential increment, branch redirect, jump redirect, stall and halt.
- Sequences a post-reset boot delay for instruction-memory read latency.

Parameters:
- PC_W, 13: PC/address width; must equal the increment stage width.
- RESET_PC, 13'h0000: PC value loaded on reset.
- BOOT_DELAY, 2: cycles after reset release before fetch starts (0..15).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_inc  in  PC_W  incremented PC (pc + 1) returned from the increment stage.
- stall  in  1  hold current PC (downstream hazard).
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  PC_W  branch destination.
- jump  in  1  unconditional jump / jump-register.
- jump_target  in  PC_W  jump destination.
- halt_req  in  1  enter HALT.
- resume  in  1  leave HALT.
- pc  out  PC_W  current instruction address (registered).
- fetch_valid  out  1  pc is a valid fetch this cycle.
- halted  out  1  block is in HALT.
- redirect  out  1  one-cycle pulse: pc was just loaded from a branch or jump target.

Behaviour:
- Interface: one clock, clk. Reset is rst: asynchronous, active-high. All state clears immediately on rst=1, independent of clk.
- Reset values:
  - pc = RESET_PC
  - state = BOOT, boot counter = 0
  - fetch_valid = 0, halted = 0, redirect = 0
- FSM states: BOOT, RUN, HALT. fetch_valid = (state==RUN). halted = (state==HALT). Both decode from the state register only.
- BOOT:
  - pc held at RESET_PC; all control inputs ignored.
  - Counter increments each edge. When it reaches BOOT_DELAY, the next state is RUN.
  - With BOOT_DELAY=0, the first edge after rst release enters RUN.
- RUN, next-PC priority (highest first):
  1. halt_req: state→HALT, pc held.
  2. jump: pc←jump_target, redirect←1.
  3. branch_taken: pc←branch_target, redirect←1.
  4. stall: pc held.
  5. otherwise: pc←pc_inc.
- Redirect and stall: redirect overrides stall (a younger hazard is flushed). jump and branch_taken together: jump wins.
- redirect is registered. It is high exactly in the cycle where pc shows the target, and 0 in all other cycles.
- HALT:
  - pc held; jump, branch and stall ignored.
  - resume=1 with halt_req=0: state→RUN next edge, pc unchanged, so fetch resumes at the held address.
  - halt_req=1 with resume=1: stays in HALT.
- Width and wrap: all PC paths are PC_W bits, no sign extension. The wrap 13'h1FFF→13'h0000 comes from pc_inc and is accepted unchanged. Targets are used verbatim, with no alignment check.
- Reset mid-operation: asserting rst in any state, including mid-redirect or HALT, returns to the reset values asynchronously and restarts the BOOT sequence.

Optional Feature:
- Macro: PC_FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_count (32 bits).
  - Increments on every RUN-state edge where pc advances (increment or redirect). It does not count stalls, halt entry, BOOT or HALT.
  - Reset value 0; saturates at 32'hFFFF_FFFF.
- Undefined: port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package kgp_pc_pkg:
  - PC_W constant and pc_t typedef.
  - State enum {BOOT, RUN, HALT}.
  - Next-PC select encoding {SEL_HOLD, SEL_INC, SEL_BRANCH, SEL_JUMP}.
- One natural sub-module, pc_next_sel: purely combinational priority encoder and next-PC mux. Its inputs are state, the control inputs, pc, pc_inc and the targets; its outputs are next_pc and the redirect flag.
- The top module holds the FSM, boot counter, PC register and optional counter.

Test Plan:
1. Boot, BOOT_DELAY=2, RESET_PC=0: release rst; bench feeds pc_inc=pc+1.
   - fetch_valid=0 for 2 cycles, then 1; pc sequence 0,0,0,1,2,3.
2. Redirect priority at pc=13'h0005: assert jump (target 13'h0100), branch_taken (target 13'h0040) and stall together for one cycle.
   - Next pc=13'h0100, redirect=1 for exactly that cycle; following pc=13'h0101.
3. Stall at pc=13'h0010: stall high 3 cycles.
   - pc stays 13'h0010 for 3 cycles, then 13'h0011; fetch_valid remains 1.
4. Wrap: jump to 13'h1FFE, then free-run.
   - pc 13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001; redirect only on the first.
5. Halt at pc=13'h0020: halt_req for 1 cycle; in HALT pulse jump (target 13'h0300) and then halt_req+resume together; then resume alone.
   - halted=1, pc stays 13'h0020 throughout HALT, jump ignored. After resume alone, halted=0 and the next pc is 13'h0021.
6. Async reset mid-redirect: assert rst between edges in the cycle after a jump.
   - pc=RESET_PC, redirect=0, fetch_valid=0 immediately, before the next clk edge.
   - With PC_FETCH_PERF_CNT_EN, fetch_count=0.
